// File: rtl/speed_ramp_sequencer_pkg.sv
// Shared types, state encodings and helpers for the speed ramp sequencer.
package speed_ramp_sequencer_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_CW    = 2'd1,
    DIR_CCW   = 2'd2,
    DIR_BRAKE = 2'd3
  } rotation_direction_t;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE      = 3'd0;
  localparam seq_state_t ST_RAMP      = 3'd1;
  localparam seq_state_t ST_HOLD      = 3'd2;
  localparam seq_state_t ST_RAMP_DOWN = 3'd3;
  localparam seq_state_t ST_BRAKE     = 3'd4;
  localparam seq_state_t ST_FAULT     = 3'd5;

  // Number of sys_clk cycles in one millisecond.
  function automatic int unsigned clk_ticks_per_ms(input int unsigned clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

  // True for the two directions that actually spin the motor.
  function automatic logic is_spin(input rotation_direction_t d);
    return (d == DIR_CW) || (d == DIR_CCW);
  endfunction

endpackage

// File: rtl/speed_ramp_sequencer_if.sv
// Command handshake bundle between the command source and the sequencer.
interface speed_ramp_sequencer_if
  import speed_ramp_sequencer_pkg::*;
#(
  parameter int unsigned rpm_width = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [rpm_width-1:0] cmd_rpm;
  rotation_direction_t  cmd_direction;

  modport master (output cmd_valid, output cmd_rpm, output cmd_direction, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rpm, input cmd_direction, output cmd_ready);
endinterface

// File: rtl/speed_ramp_sequencer_periodic_tick.sv
// Free-running divider producing a one-cycle pulse every period_cycles clocks.
module periodic_tick #(
  parameter int unsigned period_cycles = 10,
  parameter int unsigned width = (period_cycles > 1) ? $clog2(period_cycles) : 1
) (
  input  logic sys_clk,
  input  logic reset_n,
  output logic tick
);
  logic [width-1:0] count;
  logic             wrap;

  assign wrap = (count == width'(period_cycles - 1));

  // Count through the period and flag the wrap point one cycle later.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= wrap;
      count <= wrap ? '0 : count + width'(1);
    end
  end
endmodule

// File: rtl/speed_ramp_sequencer.sv
// Rate-limited speed/direction setpoint generator with reversal sequencing
// and brake-timeout supervision, sitting in front of the speed PI loop.
module speed_ramp_sequencer
  import speed_ramp_sequencer_pkg::*;
#(
  parameter int unsigned clk_freq_hz        = 27_000_000,
  parameter int unsigned rpm_counter_width  = 12,
  parameter int unsigned max_rpm            = 450,
  parameter int unsigned ramp_interval_ms   = 10,
  parameter int unsigned ramp_step_rpm      = 5,
  parameter int unsigned stop_rpm_threshold = 2,
  parameter int unsigned brake_timeout_ms   = 2000
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         enable,
  speed_ramp_sequencer_if.slave        cmd,
  input  logic [rpm_counter_width-1:0] rpm,
  input  rotation_direction_t          current_direction,
  input  logic                         clear_fault,
  output logic [rpm_counter_width-1:0] target_rpm,
  output rotation_direction_t          target_direction,
  output logic                         speed_enable,
  output logic                         busy,
  output logic                         fault
);
  localparam int unsigned rw          = rpm_counter_width;
  localparam int unsigned ms_cycles   = clk_ticks_per_ms(clk_freq_hz);
  localparam int unsigned ramp_cycles = ms_cycles * ramp_interval_ms;
  localparam int unsigned tw          = $clog2(brake_timeout_ms + 1);
  localparam logic [rw-1:0] max_w     = rw'(max_rpm);
  localparam logic [rw-1:0] step_w    = rw'(ramp_step_rpm);
  localparam logic [rw-1:0] stop_w    = rw'(stop_rpm_threshold);
  localparam logic [tw-1:0] timeout_w = tw'(brake_timeout_ms);

  seq_state_t          state, state_nxt;
  logic [rw-1:0]       goal_rpm, target_nxt;
  rotation_direction_t goal_dir, dir_nxt;
  logic [tw-1:0]       brake_ms;
  logic                ramp_tick, ms_tick, accept, reversal, stopped;
  logic                unused_dir;

  assign unused_dir    = ^current_direction;
  assign cmd.cmd_ready = (state != ST_FAULT) && enable;
  assign busy          = (state != ST_IDLE) && (state != ST_HOLD);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign reversal      = (goal_dir != target_direction) || (goal_rpm == '0);
  assign stopped       = (rpm <= stop_w);

  periodic_tick #(.period_cycles(ramp_cycles)) u_ramp_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .tick    (ramp_tick)
  );

  periodic_tick #(.period_cycles(ms_cycles)) u_ms_tick (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .tick    (ms_tick)
  );

  // One bounded step from cur toward dst; never overshoots, never wraps below 0.
  function automatic logic [rw-1:0] step_toward(input logic [rw-1:0] cur, input logic [rw-1:0] dst);
    logic [rw-1:0] diff;
    logic [rw-1:0] res;
    if (cur < dst) begin
      diff = dst - cur;
      res  = cur + ((diff > step_w) ? step_w : diff);
    end else begin
      diff = cur - dst;
      res  = cur - ((diff > step_w) ? step_w : diff);
    end
    return res;
  endfunction

  // Goal latch: last accepted command wins; cleared while disabled or faulted.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      goal_rpm <= '0;
      goal_dir <= DIR_NONE;
    end else if (!enable || (state == ST_FAULT)) begin
      goal_rpm <= '0;
      goal_dir <= DIR_NONE;
    end else if (accept) begin
      goal_dir <= cmd.cmd_direction;
      goal_rpm <= is_spin(cmd.cmd_direction) ?
                  ((cmd.cmd_rpm > max_w) ? max_w : cmd.cmd_rpm) : '0;
    end
  end

  // Brake timer in milliseconds; held at zero outside BRAKE so entry starts fresh.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      brake_ms <= '0;
    end else if (state != ST_BRAKE) begin
      brake_ms <= '0;
    end else if (ms_tick && (brake_ms < timeout_w)) begin
      brake_ms <= brake_ms + tw'(1);
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt  = state;
    target_nxt = target_rpm;
    dir_nxt    = target_direction;
    case (state)
      ST_IDLE: begin
        if (is_spin(goal_dir) && (goal_rpm != '0)) begin
          dir_nxt   = goal_dir;
          state_nxt = ST_RAMP;
        end else if (goal_dir == DIR_BRAKE) begin
          state_nxt = ST_BRAKE;
        end
      end
      ST_RAMP: begin
        if (reversal) begin
          state_nxt = ST_RAMP_DOWN;
          if (ramp_tick) target_nxt = step_toward(target_rpm, '0);
        end else if (target_rpm == goal_rpm) begin
          state_nxt = ST_HOLD;
        end else if (ramp_tick) begin
          target_nxt = step_toward(target_rpm, goal_rpm);
        end
      end
      ST_HOLD: begin
        if (reversal)                    state_nxt = ST_RAMP_DOWN;
        else if (target_rpm != goal_rpm) state_nxt = ST_RAMP;
      end
      ST_RAMP_DOWN: begin
        if (!reversal) begin
          state_nxt = ST_RAMP;
        end else if (target_rpm == '0) begin
          state_nxt = (goal_dir == DIR_NONE) ? ST_IDLE : ST_BRAKE;
        end else if (ramp_tick) begin
          target_nxt = step_toward(target_rpm, '0);
        end
      end
      ST_BRAKE: begin
        if (stopped) begin
          if (is_spin(goal_dir) && (goal_rpm != '0)) begin
            dir_nxt   = goal_dir;
            state_nxt = ST_RAMP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (brake_ms >= timeout_w) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (clear_fault) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable && (state != ST_FAULT)) state_nxt = ST_IDLE;
    case (state_nxt)
      ST_IDLE, ST_FAULT: begin
        target_nxt = '0;
        dir_nxt    = DIR_NONE;
      end
      ST_BRAKE: begin
        target_nxt = '0;
        dir_nxt    = DIR_BRAKE;
      end
      default: ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      target_rpm       <= '0;
      target_direction <= DIR_NONE;
      speed_enable     <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state            <= state_nxt;
      target_rpm       <= target_nxt;
      target_direction <= dir_nxt;
      speed_enable     <= (state_nxt != ST_IDLE) && (state_nxt != ST_FAULT);
      fault            <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_speed_ramp_sequencer.sv
// Scoreboard bench: expected target_rpm steps are queued with each command
// and popped whenever the DUT's target_rpm changes.
module tb_speed_ramp_sequencer;
  import speed_ramp_sequencer_pkg::*;

  logic                sys_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b1;
  logic                clear_fault = 1'b0;
  logic [11:0]         rpm = '0;
  rotation_direction_t current_direction = DIR_NONE;
  logic [11:0]         target_rpm;
  rotation_direction_t target_direction;
  logic                speed_enable, busy, fault;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic sb_active = 1'b0;
  logic saw_brake = 1'b0;
  logic [11:0] prev_target = '0;
  logic [11:0] exp_q[$];
  int chg_cyc[$];

  speed_ramp_sequencer_if #(.rpm_width(12)) cmd_if ();

  speed_ramp_sequencer #(
    .clk_freq_hz(10_000), .rpm_counter_width(12), .max_rpm(450),
    .ramp_interval_ms(1), .ramp_step_rpm(5), .stop_rpm_threshold(2),
    .brake_timeout_ms(20)
  ) u_dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .enable(enable), .cmd(cmd_if),
    .rpm(rpm), .current_direction(current_direction), .clear_fault(clear_fault),
    .target_rpm(target_rpm), .target_direction(target_direction),
    .speed_enable(speed_enable), .busy(busy), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // Scoreboard monitor: every target_rpm change must match the next queued value.
  always @(negedge sys_clk) begin
    if (target_direction == DIR_BRAKE) saw_brake = 1'b1;
    if (sb_active && (target_rpm !== prev_target)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: target_rpm got %0d, no change expected", target_rpm);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        chg_cyc.push_back(cyc);
        if (target_rpm !== e) begin
          miscompares++;
          $display("FAIL sb_step: target_rpm got %0d expected %0d", target_rpm, e);
        end
      end
    end
    prev_target = target_rpm;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected < 50000", cyc);
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sb_active = 1'b0;
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic send_cmd(input int r, input rotation_direction_t d);
    cmd_if.cmd_rpm = 12'(r);
    cmd_if.cmd_direction = d;
    cmd_if.cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back(12'(v));
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d steps outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    @(negedge sys_clk);
    vectors += 6;
    if (target_rpm !== 12'd0) begin miscompares++; $display("FAIL rst_target: got %0d expected 0", target_rpm); end
    if (target_direction !== DIR_NONE) begin miscompares++; $display("FAIL rst_dir: got %0d expected %0d", target_direction, DIR_NONE); end
    if (speed_enable !== 1'b0) begin miscompares++; $display("FAIL rst_speed_enable: got %b expected 0", speed_enable); end
    if (fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %b expected 0", fault); end
    if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_if.cmd_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
    enable = 1'b0;
    #1;
    vectors++;
    if (cmd_if.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL disabled_ready: got %b expected 0", cmd_if.cmd_ready); end
    enable = 1'b1;
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_ramp_up();
    sb_active = 1'b1;
    chg_cyc.delete();
    push_exp(5); push_exp(10); push_exp(15); push_exp(20); push_exp(23);
    send_cmd(23, DIR_CW);
    wait_drain(200);
    vectors++;
    if (chg_cyc.size() != 5) begin
      miscompares++;
      $display("FAIL ramp_steps: got %0d steps expected 5", chg_cyc.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        vectors++;
        if (chg_cyc[i] - chg_cyc[i-1] != 10) begin
          miscompares++;
          $display("FAIL ramp_interval: got %0d cycles expected 10", chg_cyc[i] - chg_cyc[i-1]);
        end
      end
    end
    cycles(4);
    @(negedge sys_clk);
    vectors += 3;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_busy: got %b expected 0", busy); end
    if (speed_enable !== 1'b1) begin miscompares++; $display("FAIL hold_speed_enable: got %b expected 1", speed_enable); end
    if (target_direction !== DIR_CW) begin miscompares++; $display("FAIL hold_dir: got %0d expected %0d", target_direction, DIR_CW); end
    #1;
  endtask

  task automatic test_clamp();
    for (int v = 28; v < 450; v += 5) push_exp(v);
    push_exp(450);
    send_cmd(500, DIR_CW);
    wait_drain(1200);
    cycles(30);
    @(negedge sys_clk);
    vectors += 2;
    if (target_rpm !== 12'd450) begin miscompares++; $display("FAIL clamp_target: got %0d expected 450", target_rpm); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clamp_hold: busy got %b expected 0", busy); end
    #1;
  endtask

  task automatic test_reversal();
    int n;
    apply_reset();
    sb_active = 1'b1;
    push_exp(5); push_exp(10); push_exp(15); push_exp(20);
    send_cmd(20, DIR_CW);
    wait_drain(100);
    cycles(3);
    rpm = 12'd30;
    push_exp(15); push_exp(10); push_exp(5); push_exp(0);
    send_cmd(10, DIR_CCW);
    wait_drain(100);
    n = 0;
    while (target_direction !== DIR_BRAKE && n < 20) begin @(negedge sys_clk); n++; end
    vectors += 2;
    if (target_direction !== DIR_BRAKE) begin miscompares++; $display("FAIL rev_brake_dir: got %0d expected %0d", target_direction, DIR_BRAKE); end
    if (speed_enable !== 1'b1) begin miscompares++; $display("FAIL rev_brake_enable: got %b expected 1", speed_enable); end
    cycles(20);
    @(negedge sys_clk);
    vectors++;
    if (target_direction !== DIR_BRAKE) begin miscompares++; $display("FAIL rev_wait_stop: dir got %0d expected %0d", target_direction, DIR_BRAKE); end
    #1;
    push_exp(5); push_exp(10);
    rpm = 12'd1;
    n = 0;
    while (target_direction !== DIR_CCW && n < 10) begin @(negedge sys_clk); n++; end
    vectors++;
    if (target_direction !== DIR_CCW) begin miscompares++; $display("FAIL rev_new_dir: got %0d expected %0d", target_direction, DIR_CCW); end
    wait_drain(100);
    cycles(3);
    @(negedge sys_clk);
    vectors += 2;
    if (target_rpm !== 12'd10) begin miscompares++; $display("FAIL rev_final: got %0d expected 10", target_rpm); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rev_hold: busy got %b expected 0", busy); end
    #1;
    rpm = '0;
  endtask

  task automatic test_brake_timeout();
    int n;
    apply_reset();
    rpm = 12'd50;
    send_cmd(0, DIR_BRAKE);
    n = 0;
    while (target_direction !== DIR_BRAKE && n < 10) begin @(negedge sys_clk); n++; end
    vectors++;
    if (target_direction !== DIR_BRAKE) begin miscompares++; $display("FAIL to_brake: dir got %0d expected %0d", target_direction, DIR_BRAKE); end
    n = 0;
    while (fault !== 1'b1 && n < 300) begin @(negedge sys_clk); n++; end
    vectors++;
    if (n < 191 || n > 202) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles expected 191..202", n); end
    vectors += 4;
    if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_set: got %b expected 1", fault); end
    if (speed_enable !== 1'b0) begin miscompares++; $display("FAIL fault_enable: got %b expected 0", speed_enable); end
    if (cmd_if.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL fault_ready: got %b expected 0", cmd_if.cmd_ready); end
    if (target_direction !== DIR_NONE) begin miscompares++; $display("FAIL fault_dir: got %0d expected %0d", target_direction, DIR_NONE); end
    #1;
    send_cmd(30, DIR_CW);
    cycles(3);
    @(negedge sys_clk);
    vectors += 2;
    if (fault !== 1'b1) begin miscompares++; $display("FAIL fault_sticky: got %b expected 1", fault); end
    if (target_rpm !== 12'd0) begin miscompares++; $display("FAIL fault_refuse: target got %0d expected 0", target_rpm); end
    @(posedge sys_clk);
    #1 clear_fault = 1'b1;
    @(posedge sys_clk);
    #1 clear_fault = 1'b0;
    @(negedge sys_clk);
    vectors += 3;
    if (fault !== 1'b0) begin miscompares++; $display("FAIL clear_fault: got %b expected 0", fault); end
    if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL clear_ready: got %b expected 1", cmd_if.cmd_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_idle: busy got %b expected 0", busy); end
    #1;
    rpm = '0;
  endtask

  task automatic test_abort_reversal();
    apply_reset();
    sb_active = 1'b1;
    push_exp(5); push_exp(10); push_exp(15);
    send_cmd(15, DIR_CW);
    wait_drain(100);
    cycles(3);
    saw_brake = 1'b0;
    push_exp(10);
    send_cmd(10, DIR_CCW);
    wait_drain(100);
    push_exp(15);
    send_cmd(15, DIR_CW);
    wait_drain(100);
    cycles(3);
    @(negedge sys_clk);
    vectors += 4;
    if (saw_brake !== 1'b0) begin miscompares++; $display("FAIL abort_no_brake: saw_brake got %b expected 0", saw_brake); end
    if (target_direction !== DIR_CW) begin miscompares++; $display("FAIL abort_dir: got %0d expected %0d", target_direction, DIR_CW); end
    if (target_rpm !== 12'd15) begin miscompares++; $display("FAIL abort_target: got %0d expected 15", target_rpm); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_hold: busy got %b expected 0", busy); end
    #1;
  endtask

  task automatic test_tick_collision();
    int n;
    apply_reset();
    sb_active = 1'b1;
    push_exp(5); push_exp(10); push_exp(15); push_exp(12);
    send_cmd(30, DIR_CW);
    n = 0;
    while (target_rpm !== 12'd10 && n < 100) begin @(posedge sys_clk); #1; n++; end
    repeat (9) @(posedge sys_clk);
    #1;
    cmd_if.cmd_rpm = 12'd12;
    cmd_if.cmd_direction = DIR_CW;
    cmd_if.cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1 cmd_if.cmd_valid = 1'b0;
    vectors++;
    if (target_rpm !== 12'd15) begin miscompares++; $display("FAIL collide_old_goal: got %0d expected 15", target_rpm); end
    wait_drain(100);
    cycles(3);
    @(negedge sys_clk);
    vectors += 2;
    if (target_rpm !== 12'd12) begin miscompares++; $display("FAIL collide_settle: got %0d expected 12", target_rpm); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL collide_hold: busy got %b expected 0", busy); end
    #1;
  endtask

  task automatic test_reset_mid_ramp();
    apply_reset();
    sb_active = 1'b1;
    push_exp(5); push_exp(10);
    send_cmd(30, DIR_CW);
    wait_drain(100);
    sb_active = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (target_rpm !== 12'd10) begin miscompares++; $display("FAIL pre_reset_target: got %0d expected 10", target_rpm); end
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (target_rpm !== 12'd0) begin miscompares++; $display("FAIL async_target: got %0d expected 0", target_rpm); end
    if (target_direction !== DIR_NONE) begin miscompares++; $display("FAIL async_dir: got %0d expected %0d", target_direction, DIR_NONE); end
    if (speed_enable !== 1'b0) begin miscompares++; $display("FAIL async_enable: got %b expected 0", speed_enable); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", busy); end
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_rpm = '0;
    cmd_if.cmd_direction = DIR_NONE;
    test_reset();
    test_ramp_up();
    test_clamp();
    test_reversal();
    test_brake_timeout();
    test_abort_reversal();
    test_tick_collision();
    test_reset_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
